// File: rtl/wb_scheduler_pkg.sv
// Shared types and constants for the writeback scheduler: source indices,
// CDB slot count and the queued result entry.
package wb_scheduler_pkg;

  localparam int NUM_WB_SRC   = 3;
  localparam int NUM_WB_SLOTS = 2;

  localparam logic [1:0] SRC_MUL = 2'd0;
  localparam logic [1:0] SRC_DIV = 2'd1;
  localparam logic [1:0] SRC_MEM = 2'd2;

  // prd field is sized for up to 256 physical registers; the top narrows it.
  localparam int WB_PRD_W = 8;

  typedef struct packed {
    logic [WB_PRD_W-1:0] prd;
    logic [31:0]         data;
    logic [6:0]          rob_idx;
  } wb_entry_t;

  function automatic logic [1:0] next_src(input logic [1:0] s);
    return (s == SRC_MEM) ? SRC_MUL : s + 2'd1;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Per-source result queue: power-of-two depth, registered count, flush
// clears pointers and count at the next edge; payload storage is not reset.
module wb_fifo #(
  parameter int  DEPTH   = 2,
  parameter type entry_t = wb_scheduler_pkg::wb_entry_t
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  entry_t                 push_data,
  input  logic                   pop,
  input  logic                   flush,
  output entry_t                 head,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  entry_t        mem_q [DEPTH];
  logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign do_push = push && (cnt_q != CW'(DEPTH));
  assign do_pop  = pop && (cnt_q != '0);

  always_comb begin
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (flush) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else begin
      // Pointers wrap naturally because DEPTH is a power of two.
      if (do_push) wr_d = wr_q + 1'b1;
      if (do_pop)  rd_d = rd_q + 1'b1;
      cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_q] <= push_data;
  end

  assign head  = mem_q[rd_q];
  assign count = cnt_q;

endmodule

// File: rtl/wb_scheduler.sv
// Arbitrates MUL/DIV/MEM results onto two shared CDB slots with a rotating
// priority pointer; grants depend only on registered queue state.
module wb_scheduler
  import wb_scheduler_pkg::*;
#(
  parameter int  NUM_PHYS_REGS = 64,
  parameter int  FIFO_DEPTH    = 2,
  localparam int PREG_BITS     = $clog2(NUM_PHYS_REGS)
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [2:0]                             src_valid,
  output logic [2:0]                             src_ready,
  input  logic [2:0][PREG_BITS-1:0]              src_prd,
  input  logic [2:0][31:0]                       src_data,
  input  logic [2:0][6:0]                        src_rob_idx,
  output logic [NUM_WB_SLOTS-1:0]                wb_valid,
  output logic [NUM_WB_SLOTS-1:0][PREG_BITS-1:0] wb_tag,
  output logic [NUM_WB_SLOTS-1:0][31:0]          wb_data,
  output logic [NUM_WB_SLOTS-1:0][6:0]           wb_rob_idx,
  input  logic                                   flush,
  output logic                                   busy,
  output logic [1:0]                             dbg_rr_ptr
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  wb_entry_t               push_ent [NUM_WB_SRC];
  wb_entry_t               head     [NUM_WB_SRC];
  logic [CW-1:0]           cnt      [NUM_WB_SRC];
  logic [NUM_WB_SRC-1:0]   push, pop, nonempty;
  logic [1:0]              rr_ptr_q, rr_ptr_d;
  logic [1:0]              scan_src, last_src;
  logic [NUM_WB_SLOTS-1:0] slot_vld;
  logic [1:0]              slot_src [NUM_WB_SLOTS];

  for (genvar i = 0; i < NUM_WB_SRC; i++) begin : g_src
    assign push_ent[i] = '{prd: WB_PRD_W'(src_prd[i]), data: src_data[i],
                           rob_idx: src_rob_idx[i]};
    assign src_ready[i] = cnt[i] < CW'(FIFO_DEPTH);
    assign push[i]      = src_valid[i] && src_ready[i] && !flush;
    assign nonempty[i]  = cnt[i] != '0;

    wb_fifo #(.DEPTH(FIFO_DEPTH), .entry_t(wb_entry_t)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push[i]),
      .push_data (push_ent[i]),
      .pop       (pop[i]),
      .flush     (flush),
      .head      (head[i]),
      .count     (cnt[i])
    );
  end

  // Scan from rr_ptr; first non-empty head takes slot 0, second takes slot 1.
  always_comb begin
    slot_vld = '0;
    slot_src = '{default: 2'd0};
    pop      = '0;
    scan_src = rr_ptr_q;
    last_src = rr_ptr_q;
    rr_ptr_d = rr_ptr_q;
    for (int k = 0; k < NUM_WB_SRC; k++) begin
      if (nonempty[scan_src]) begin
        if (!slot_vld[0]) begin
          slot_vld[0]   = 1'b1;
          slot_src[0]   = scan_src;
          pop[scan_src] = 1'b1;
          last_src      = scan_src;
        end else if (!slot_vld[1]) begin
          slot_vld[1]   = 1'b1;
          slot_src[1]   = scan_src;
          pop[scan_src] = 1'b1;
          last_src      = scan_src;
        end
      end
      scan_src = next_src(scan_src);
    end
    if (slot_vld != '0) rr_ptr_d = next_src(last_src);
  end

  always_comb begin
    for (int k = 0; k < NUM_WB_SLOTS; k++) begin
      wb_valid[k]   = slot_vld[k];
      wb_tag[k]     = '0;
      wb_data[k]    = '0;
      wb_rob_idx[k] = '0;
      if (slot_vld[k]) begin
        wb_tag[k]     = PREG_BITS'(head[slot_src[k]].prd);
        wb_data[k]    = head[slot_src[k]].data;
        wb_rob_idx[k] = head[slot_src[k]].rob_idx;
      end
    end
  end

  // The pointer is not touched by flush: grants in the flush cycle still count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rr_ptr_q <= SRC_MUL;
    else      rr_ptr_q <= rr_ptr_d;
  end

  assign busy       = |nonempty;
  assign dbg_rr_ptr = rr_ptr_q;

endmodule

// File: tb/tb_wb_scheduler.sv
// Directed bench for wb_scheduler: a per-cycle vector table with fixed
// payloads, then scoreboard-checked sequences for backpressure, flush,
// fairness and asynchronous reset.
module tb_wb_scheduler;
  import wb_scheduler_pkg::*;

  localparam int PB = 6;
  localparam int EW = PB + 32 + 7;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic [2:0]           src_valid = '0;
  logic [2:0]           src_ready;
  logic [2:0][PB-1:0]   src_prd = '0;
  logic [2:0][31:0]     src_data = '0;
  logic [2:0][6:0]      src_rob_idx = '0;
  logic [1:0]           wb_valid;
  logic [1:0][PB-1:0]   wb_tag;
  logic [1:0][31:0]     wb_data;
  logic [1:0][6:0]      wb_rob_idx;
  logic                 flush = 1'b0;
  logic                 busy;
  logic [1:0]           dbg_rr_ptr;

  wb_scheduler #(.NUM_PHYS_REGS(64), .FIFO_DEPTH(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .src_valid   (src_valid),
    .src_ready   (src_ready),
    .src_prd     (src_prd),
    .src_data    (src_data),
    .src_rob_idx (src_rob_idx),
    .wb_valid    (wb_valid),
    .wb_tag      (wb_tag),
    .wb_data     (wb_data),
    .wb_rob_idx  (wb_rob_idx),
    .flush       (flush),
    .busy        (busy),
    .dbg_rr_ptr  (dbg_rr_ptr)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_errors = 0;

  logic [EW-1:0] exp_q[$];
  logic [4:0]    seq [3];
  int            starve [3];
  int            grant_cnt [3];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [2:0] valid;
    logic       flush;
    logic [2:0] exp_ready;
    logic [1:0] exp_wbv;
    logic [1:0] exp_src0;
    logic [1:0] exp_src1;
    logic [1:0] exp_rr;
    logic       exp_busy;
  } vec_t;

  localparam int NV = 16;
  vec_t        vecs [NV];
  logic [PB-1:0] fix_prd  [3];
  logic [31:0]   fix_data [3];
  logic [6:0]    fix_rob  [3];

  function automatic vec_t mk(input logic [2:0] v, input logic f, input logic [1:0] wbv,
                              input logic [1:0] s0, input logic [1:0] s1,
                              input logic [1:0] rr, input logic b);
    vec_t r;
    r.valid = v; r.flush = f; r.exp_ready = 3'b111; r.exp_wbv = wbv;
    r.exp_src0 = s0; r.exp_src1 = s1; r.exp_rr = rr; r.exp_busy = b;
    return r;
  endfunction

  task automatic check_slot(input string name, input int k, input logic vld, input logic [1:0] s);
    logic [PB-1:0] et;
    logic [31:0]   ed;
    logic [6:0]    er;
    et = vld ? fix_prd[s]  : '0;
    ed = vld ? fix_data[s] : '0;
    er = vld ? fix_rob[s]  : '0;
    check($sformatf("%s tag%0d", name, k),  64'(wb_tag[k]),     64'(et));
    check($sformatf("%s data%0d", name, k), 64'(wb_data[k]),    64'(ed));
    check($sformatf("%s rob%0d", name, k),  64'(wb_rob_idx[k]), 64'(er));
  endtask

  // ---------------- driver / scoreboard ----------------
  task automatic do_reset();
    src_valid = '0;
    flush     = 1'b0;
    rst       = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    for (int i = 0; i < 3; i++) begin
      seq[i] = '0; starve[i] = 0; grant_cnt[i] = 0;
    end
  endtask

  task automatic sb_check();
    int            cnt_s [3];
    int            npend;
    int            found;
    int            s;
    logic [2:0]    granted;
    logic [EW-1:0] act;
    cnt_s = '{0, 0, 0};
    granted = '0;
    foreach (exp_q[j]) begin
      s = int'(exp_q[j][6:5]);
      if (s < 3) cnt_s[s]++;
    end
    npend = 0;
    for (int i = 0; i < 3; i++) begin
      if (cnt_s[i] != 0) npend++;
      check($sformatf("ready%0d", i), 64'(src_ready[i]), 64'(cnt_s[i] < 2));
    end
    check("busy", 64'(busy), 64'(exp_q.size() != 0));
    check("grant count", 64'($countones(wb_valid)), 64'((npend > 2) ? 2 : npend));
    check("slot packing", 64'(wb_valid == 2'b10), 64'(0));
    for (int k = 0; k < 2; k++) begin
      act = {wb_tag[k], wb_data[k], wb_rob_idx[k]};
      if (wb_valid[k]) begin
        s = int'(wb_rob_idx[k][6:5]);
        found = -1;
        foreach (exp_q[j]) begin
          if (found < 0 && int'(exp_q[j][6:5]) == s) found = j;
        end
        if (found < 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL slot%0d unexpected: got 0x%0h expected no result", k, act);
        end else begin
          check($sformatf("slot%0d payload", k), 64'(act), 64'(exp_q[found]));
          exp_q.delete(found);
          granted[s] = 1'b1;
          grant_cnt[s]++;
        end
      end else begin
        check($sformatf("slot%0d idle payload", k), 64'(act), 64'(0));
      end
    end
    for (int i = 0; i < 3; i++) begin
      if (cnt_s[i] != 0) begin
        if (granted[i]) starve[i] = 0;
        else            starve[i]++;
        n_checks++;
        if (starve[i] > 1) begin
          n_errors++;
          $display("FAIL src%0d wait: got %0d ungranted cycles expected at most 1", i, starve[i]);
        end
      end else begin
        starve[i] = 0;
      end
    end
  endtask

  // One cycle: drive at negedge, model the edge, check at the next negedge.
  task automatic step(input logic [2:0] valid, input logic fl);
    logic [2:0]    acc;
    logic [EW-1:0] ent [3];
    for (int i = 0; i < 3; i++) begin
      src_prd[i]     = PB'(i * 16) + PB'(seq[i]);
      src_data[i]    = 32'hC0DE_0000 | (32'(i) << 8) | 32'(seq[i]);
      src_rob_idx[i] = {2'(i), seq[i]};
      ent[i]         = {src_prd[i], src_data[i], src_rob_idx[i]};
    end
    src_valid = valid;
    flush     = fl;
    acc       = valid & src_ready & {3{!fl}};
    @(posedge clk);
    if (fl) exp_q.delete();
    for (int i = 0; i < 3; i++) begin
      if (acc[i]) begin
        exp_q.push_back(ent[i]);
        seq[i] = seq[i] + 5'd1;
      end
    end
    @(negedge clk);
    src_valid = '0;
    flush     = 1'b0;
    sb_check();
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 10) begin
      step(3'b000, 1'b0);
      n++;
    end
    check({name, " drained"}, 64'(exp_q.size()), 64'(0));
  endtask

  // ---------------- test ----------------
  initial begin
    int div_left;
    logic stall_seen;

    fix_prd  = '{6'd5, 6'd9, 6'd33};
    fix_data = '{32'h0000_1234, 32'h0000_D1D1, 32'h0000_BEEF};
    fix_rob  = '{7'd3, 7'd17, 7'd100};

    //               valid   fl    wbv    s0 s1 rr busy
    vecs[0]  = mk(3'b001, 1'b0, 2'b01, 0, 0, 0, 1);
    vecs[1]  = mk(3'b000, 1'b0, 2'b00, 0, 0, 1, 0);
    vecs[2]  = mk(3'b111, 1'b0, 2'b11, 1, 2, 1, 1);
    vecs[3]  = mk(3'b000, 1'b0, 2'b01, 0, 0, 0, 1);
    vecs[4]  = mk(3'b000, 1'b0, 2'b00, 0, 0, 1, 0);
    vecs[5]  = mk(3'b100, 1'b0, 2'b01, 2, 0, 1, 1);
    vecs[6]  = mk(3'b000, 1'b0, 2'b00, 0, 0, 0, 0);
    vecs[7]  = mk(3'b111, 1'b0, 2'b11, 0, 1, 0, 1);
    vecs[8]  = mk(3'b000, 1'b0, 2'b01, 2, 0, 2, 1);
    vecs[9]  = mk(3'b000, 1'b0, 2'b00, 0, 0, 0, 0);
    vecs[10] = mk(3'b010, 1'b0, 2'b01, 1, 0, 0, 1);
    vecs[11] = mk(3'b010, 1'b0, 2'b01, 1, 0, 2, 1);
    vecs[12] = mk(3'b000, 1'b0, 2'b00, 0, 0, 2, 0);
    vecs[13] = mk(3'b111, 1'b0, 2'b11, 2, 0, 2, 1);
    vecs[14] = mk(3'b111, 1'b1, 2'b00, 0, 0, 1, 0);
    vecs[15] = mk(3'b000, 1'b0, 2'b00, 0, 0, 1, 0);

    for (int i = 0; i < 3; i++) begin
      src_prd[i] = fix_prd[i]; src_data[i] = fix_data[i]; src_rob_idx[i] = fix_rob[i];
    end

    // Reset values, sampled while reset is held.
    @(negedge clk);
    check("reset wb_valid", 64'(wb_valid), 64'(0));
    check("reset busy", 64'(busy), 64'(0));
    check("reset ready", 64'(src_ready), 64'(3'b111));
    check("reset rr", 64'(dbg_rr_ptr), 64'(0));
    check_slot("reset", 0, 1'b0, 2'd0);
    @(negedge clk);
    rst = 1'b1;

    for (int v = 0; v < NV; v++) begin
      src_valid = vecs[v].valid;
      flush     = vecs[v].flush;
      @(posedge clk);
      @(negedge clk);
      src_valid = '0;
      flush     = 1'b0;
      check($sformatf("v%0d wb_valid", v), 64'(wb_valid),   64'(vecs[v].exp_wbv));
      check($sformatf("v%0d ready", v),    64'(src_ready),  64'(vecs[v].exp_ready));
      check($sformatf("v%0d busy", v),     64'(busy),       64'(vecs[v].exp_busy));
      check($sformatf("v%0d rr", v),       64'(dbg_rr_ptr), 64'(vecs[v].exp_rr));
      check_slot($sformatf("v%0d", v), 0, vecs[v].exp_wbv[0], vecs[v].exp_src0);
      check_slot($sformatf("v%0d", v), 1, vecs[v].exp_wbv[1], vecs[v].exp_src1);
    end

    // DIV backpressure while MUL and MEM stay saturated.
    do_reset();
    div_left   = 4;
    stall_seen = 1'b0;
    for (int c = 0; c < 20 && div_left > 0; c++) begin
      if (!src_ready[1]) stall_seen = 1'b1;
      else               div_left--;
      step({1'b1, 1'b1, 1'b1}, 1'b0);
    end
    check("div all accepted", 64'(div_left), 64'(0));
    check("div ready dropped", 64'(stall_seen), 64'(1));
    drain("backpressure");

    // Flush with queues busy and MEM pushing in the flush cycle.
    do_reset();
    for (int c = 0; c < 4; c++) step(3'b111, 1'b0);
    step(3'b100, 1'b1);
    check("flush wb_valid", 64'(wb_valid), 64'(0));
    check("flush busy", 64'(busy), 64'(0));
    check("flush ready", 64'(src_ready), 64'(3'b111));
    for (int c = 0; c < 3; c++) begin
      step(3'b000, 1'b0);
      check($sformatf("post-flush wb_valid c%0d", c), 64'(wb_valid), 64'(0));
    end

    // Fairness over 30 cycles of continuous traffic.
    do_reset();
    for (int c = 0; c < 30; c++) step(3'b111, 1'b0);
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (grant_cnt[i] < 19 || grant_cnt[i] > 21) begin
        n_errors++;
        $display("FAIL src%0d grants: got %0d expected 19..21", i, grant_cnt[i]);
      end
    end
    drain("fairness");

    // Asynchronous reset between clock edges.
    do_reset();
    step(3'b111, 1'b0);
    step(3'b111, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    check("async rst wb_valid", 64'(wb_valid), 64'(0));
    check("async rst busy", 64'(busy), 64'(0));
    check("async rst ready", 64'(src_ready), 64'(3'b111));
    check("async rst rr", 64'(dbg_rr_ptr), 64'(0));
    exp_q.delete();
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step(3'b000, 1'b0);
      check($sformatf("post-rst wb_valid c%0d", c), 64'(wb_valid), 64'(0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
